ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset).
- It is the transmit counterpart to the PS/2 receive, validation and translation path, and shares the same ps2c/ps2d lines.
- Drives both lines open-collector through output-enable signals. Outputs rx_en so the receiver is disabled while a transmission is in progress.

---
 rtl/ps2_host_tx.sv | 174 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked by the device,
// then the ack bit. Both lines are driven open-collector through registered output enables.
module ps2_host_tx #(
  parameter int unsigned RTS_CYCLES     = 6000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       rx_en,
  output logic       tx_done_tick,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int unsigned RTS_W = $clog2(RTS_CYCLES);
  localparam int unsigned FLT_W = $clog2(FILTER_LEN) + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK} state_t;

  logic [1:0]       c_sync, d_sync;
  logic             filt_q, fall_tick_q;
  logic [FLT_W-1:0] flt_cnt_q;

  state_t           state_q, state_d;
  logic [RTS_W-1:0] rts_q, rts_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [8:0]       shreg_q, shreg_d;
  logic [3:0]       n_q, n_d;
  logic             ps2c_oe_d, ps2d_oe_d, tx_idle_d, done_d, ack_err_d, to_err_d;

  // Synchronizers and clock glitch filter; fall_tick marks a filtered 1->0 transition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync      <= 2'b11;
      d_sync      <= 2'b11;
      filt_q      <= 1'b1;
      flt_cnt_q   <= '0;
      fall_tick_q <= 1'b0;
    end else begin
      c_sync      <= {c_sync[0], ps2c_in};
      d_sync      <= {d_sync[0], ps2d_in};
      fall_tick_q <= 1'b0;
      if (c_sync[1] == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_q      <= c_sync[1];
        flt_cnt_q   <= '0;
        fall_tick_q <= filt_q;
      end else begin
        flt_cnt_q <= flt_cnt_q + FLT_W'(1);
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rts_q        <= '0;
      wd_q         <= '0;
      shreg_q      <= '0;
      n_q          <= '0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      rx_en        <= 1'b1;
      tx_done_tick <= 1'b0;
      ack_err      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rts_q        <= rts_d;
      wd_q         <= wd_d;
      shreg_q      <= shreg_d;
      n_q          <= n_d;
      ps2c_oe      <= ps2c_oe_d;
      ps2d_oe      <= ps2d_oe_d;
      tx_idle      <= tx_idle_d;
      rx_en        <= tx_idle_d;
      tx_done_tick <= done_d;
      ack_err      <= ack_err_d;
      timeout_err  <= to_err_d;
    end
  end

  // Next state; line enables are derived from the next state so they stay registered
  always_comb begin
    state_d   = state_q;
    rts_d     = rts_q;
    wd_d      = wd_q;
    shreg_d   = shreg_q;
    n_d       = n_q;
    done_d    = 1'b0;
    ack_err_d = ack_err;
    to_err_d  = timeout_err;
    ps2c_oe_d = 1'b0;
    ps2d_oe_d = 1'b0;
    tx_idle_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_ps2) begin
          shreg_d   = {~^din, din};
          ack_err_d = 1'b0;
          to_err_d  = 1'b0;
          rts_d     = RTS_W'(RTS_CYCLES - 1);
          state_d   = RTS;
        end
      end
      RTS: begin
        if (rts_q == '0) begin
          wd_d    = '0;
          state_d = START;
        end else begin
          rts_d = rts_q - RTS_W'(1);
        end
      end
      START: begin
        if (fall_tick_q) begin
          n_d     = 4'd8;
          state_d = DATA;
        end
      end
      DATA: begin
        if (fall_tick_q) begin
          shreg_d = {1'b0, shreg_q[8:1]};
          if (n_q == 4'd0) state_d = STOP;
          else             n_d = n_q - 4'd1;
        end
      end
      STOP: begin
        if (fall_tick_q) state_d = ACK;
      end
      ACK: begin
        if (fall_tick_q) begin
          ack_err_d = d_sync[1];
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog covers the device-clocked phases and overrides a coincident fall_tick
    if (state_q inside {START, DATA, STOP, ACK}) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        to_err_d  = 1'b1;
        done_d    = 1'b0;
        ack_err_d = ack_err;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end

    case (state_d)
      RTS:     ps2c_oe_d = 1'b1;
      START:   ps2d_oe_d = 1'b1;
      DATA:    ps2d_oe_d = ~shreg_d[0];
      default: ps2d_oe_d = 1'b0;
    endcase
    tx_idle_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device model, expected-frame scoreboard
// and a monitor that checks every completion or abort against the queue.
module tb_ps2_host_tx;

  localparam int unsigned RTS  = 16;
  localparam int unsigned FLT  = 8;
  localparam int unsigned TO   = 1000;
  localparam int          HALF = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, rx_en, tx_done_tick, ack_err, timeout_err;

  // Open-collector wired lines with pull-ups
  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  ps2_host_tx #(.RTS_CYCLES(RTS), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .wr_ps2(wr_ps2), .din(din), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
    .tx_idle(tx_idle), .rx_en(rx_en), .tx_done_tick(tx_done_tick),
    .ack_err(ack_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] frame;
    logic        ack_err;
    logic        timeout;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [10:0] cap_frame = '0;
  logic        to_prev = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Wire order: start, data LSB first, odd parity, stop
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Monitor: each completion or abort consumes one expectation
  always @(negedge clk) begin
    if (reset) begin
      chk("rx_en_eq_tx_idle", 32'(rx_en), 32'(tx_idle));
      if (tx_done_tick || (timeout_err && !to_prev)) begin
        if (exp_q.size() == 0) begin
          chk("event_without_expectation", 32'(tx_done_tick | timeout_err), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("done_tick", 32'(tx_done_tick), 32'(!e.timeout));
          chk("timeout_err", 32'(timeout_err), 32'(e.timeout));
          chk("ack_err", 32'(ack_err), 32'(e.ack_err));
          chk("tx_idle_at_end", 32'(tx_idle), 32'(1));
          chk("oe_at_end", 32'({ps2c_oe, ps2d_oe}), 32'(0));
          if (!e.timeout) chk("frame_bits", 32'(cap_frame), 32'(e.frame));
        end
      end
    end
    to_prev = timeout_err;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    wr_ps2 = 1'b1;
    din    = b;
    cyc(1);
    wr_ps2 = 1'b0;
    chk("tx_idle_drops", 32'(tx_idle), 32'(0));
  endtask

  // Host holds clock low exactly RTS cycles, then releases it with the start bit driven
  task automatic rts_phase();
    int n = 0;
    @(negedge clk);
    while (ps2c_oe === 1'b1 && n < 200) begin
      n++;
      if (ps2d_oe !== 1'b0) chk("ps2d_oe_in_rts", 32'(ps2d_oe), 32'(0));
      @(negedge clk);
    end
    chk("rts_length", 32'(n), 32'(RTS));
    chk("start_bit_oe", 32'({ps2c_oe, ps2d_oe}), 32'(1));
  endtask

  // Device: sample data while clock is high, then pulse clock low; ack driven after stop
  task automatic device(input int npulse, input bit ack_low, input int glitch_at, input int busy_at);
    cap_frame = '0;
    for (int k = 0; k < npulse; k++) begin
      if (k == glitch_at) begin
        cyc(10); dev_c_low = 1'b1; cyc(3); dev_c_low = 1'b0; cyc(HALF - 13);
      end else begin
        cyc(HALF);
      end
      if (k < 11) cap_frame[k] = ps2d_in;
      dev_c_low = 1'b1;
      if (k == 10) dev_d_low = ack_low;
      if (k == busy_at) begin
        wr_ps2 = 1'b1; din = 8'h55; cyc(1); wr_ps2 = 1'b0; cyc(HALF - 1);
      end else begin
        cyc(HALF);
      end
      dev_c_low = 1'b0;
    end
    dev_d_low = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (tx_idle !== 1'b1 && g < 300) begin
      g++;
      cyc(1);
    end
    chk(name, 32'(tx_idle), 32'(1));
    cyc(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic frame(input logic [7:0] b, input bit ack_low, input int glitch_at, input int busy_at);
    exp_q.push_back('{frame: ref_frame(b), ack_err: !ack_low, timeout: 1'b0});
    send(b);
    rts_phase();
    device(12, ack_low, glitch_at, busy_at);
    wait_idle("idle_after_frame");
  endtask

  initial begin
    int n;
    logic [7:0] b;

    cyc(2);
    chk("reset_outputs", 32'({ps2c_oe, ps2d_oe, tx_idle, rx_en, tx_done_tick, ack_err, timeout_err}),
        32'(7'b0011000));
    @(negedge clk);
    reset = 1'b1;
    cyc(20);

    frame(8'hED, 1'b1, -1, -1);
    chk("ack_ok", 32'(ack_err), 32'(0));

    frame(8'h03, 1'b0, -1, -1);
    cyc(50);
    chk("ack_err_sticky", 32'(ack_err), 32'(1));

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back('{frame: ref_frame(b), ack_err: 1'b0, timeout: 1'b0});
      exp_q[exp_q.size()-1].ack_err = 1'b0;
      send(b);
      if (i == 0) chk("ack_err_cleared_on_accept", 32'(ack_err), 32'(0));
      rts_phase();
      n = $urandom_range(0, 1);
      exp_q[exp_q.size()-1].ack_err = (n == 0);
      device(12, n[0], int'($urandom_range(1, 9)), int'($urandom_range(2, 8)));
      wait_idle("idle_after_random_frame");
    end

    // Device never clocks: watchdog abort
    exp_q.push_back('{frame: '0, ack_err: 1'b0, timeout: 1'b1});
    send(8'($urandom));
    rts_phase();
    n = 0;
    while (timeout_err !== 1'b1 && n < 3 * TO) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TO));
    cyc(20);
    chk("no_late_done", 32'(tx_done_tick), 32'(0));
    chk("scoreboard_drained_timeout", 32'(exp_q.size()), 32'(0));

    // Reset mid-DATA after four shifts; bit 4 of 0x0F is 0 so data is being pulled low
    send(8'h0F);
    rts_phase();
    device(5, 1'b0, -1, -1);
    cyc(5);
    chk("data_low_before_reset", 32'(ps2d_oe), 32'(1));
    #2 reset = 1'b0;
    #1 chk("async_reset_outputs", 32'({ps2c_oe, ps2d_oe, tx_idle, rx_en, ack_err, timeout_err}),
           32'(6'b001100));
    cyc(3);
    @(negedge clk);
    reset = 1'b1;
    cyc(20);
    frame(8'hFF, 1'b1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
